// File: rtl/wb_stream_mailbox.sv
// wb_stream_mailbox: 8-bit Wishbone classic slave bridging register accesses to a TX byte FIFO
// (CPU -> peripheral) and an RX byte FIFO (peripheral -> CPU), with a level interrupt.
module wb_stream_mailbox #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  BASE_ADDR  = 8'h60
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  localparam logic [2:0] OffData    = 3'd0;
  localparam logic [2:0] OffStatus  = 3'd1;
  localparam logic [2:0] OffCtrl    = 3'd2;
  localparam logic [2:0] OffRxLevel = 3'd3;
  localparam logic [2:0] OffTxLevel = 3'd4;

  // Bus handshake state
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic [7:0] dat_q, dat_d;

  // Control and sticky error flags
  logic [2:0] ctrl_q, ctrl_d;
  logic       tx_ovf_q, tx_ovf_d;
  logic       rx_udf_q, rx_udf_d;

  // TX FIFO
  logic [7:0]      tx_mem_q [FIFO_DEPTH];
  logic [7:0]      tx_mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] tx_wptr_q, tx_wptr_d;
  logic [PtrW-1:0] tx_rptr_q, tx_rptr_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;

  // RX FIFO
  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [7:0]      rx_mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] rx_wptr_q, rx_wptr_d;
  logic [PtrW-1:0] rx_rptr_q, rx_rptr_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;

  // Address decode; the offset is taken modulo 256 so only BASE_ADDR..BASE_ADDR+4 match.
  logic [7:0] adr_off;
  logic [2:0] offset;
  logic       sel;
  logic       access;
  logic       wr_en;
  logic       rd_en;

  assign adr_off = wb_adr_i - BASE_ADDR;
  assign offset  = adr_off[2:0];
  assign sel     = wb_cyc_i & wb_stb_i & (adr_off <= 8'd4);

  // One access per select: blocked during the ack cycle and until the select drops.
  assign access = sel & ~ack_q & ~done_q;
  assign wr_en  = access & wb_we_i;
  assign rd_en  = access & ~wb_we_i;

  // FIFO status, always from the registered counts
  logic tx_empty, tx_full, rx_empty, rx_full;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == DepthCnt);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DepthCnt);

  // Per-register strobes for the committing access
  logic data_wr, data_rd, status_wr, ctrl_wr, flush;

  assign data_wr   = wr_en & (offset == OffData);
  assign data_rd   = rd_en & (offset == OffData);
  assign status_wr = wr_en & (offset == OffStatus);
  assign ctrl_wr   = wr_en & (offset == OffCtrl);
  assign flush     = ctrl_wr & wb_dat_i[7];

  // FIFO events
  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_push = data_wr & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;
  assign rx_pop  = data_rd & ~rx_empty;

  // Stream-side outputs
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_mem_q[tx_rptr_q];
  assign rx_ready = ~rx_full;

  // Bus outputs
  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

  // Level interrupt built only from registered state
  assign irq = (ctrl_q[0] & ~rx_empty) |
               (ctrl_q[1] & tx_empty)  |
               (ctrl_q[2] & (tx_ovf_q | rx_udf_q));

  // Read data mux, evaluated on pre-access state
  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OffData:    rd_data = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
      OffStatus:  rd_data = {2'b00, rx_udf_q, tx_ovf_q, tx_full, tx_empty, rx_full, rx_empty};
      OffCtrl:    rd_data = {5'b00000, ctrl_q};
      OffRxLevel: rd_data = 8'(rx_cnt_q);
      OffTxLevel: rd_data = 8'(tx_cnt_q);
      default:    rd_data = 8'h00;
    endcase
  end

  // Ack, read-data and select-tracking next state
  always_comb begin
    ack_d  = access;
    dat_d  = rd_en ? rd_data : 8'h00;
    done_d = done_q;
    if (!sel) begin
      done_d = 1'b0;
    end else if (access) begin
      done_d = 1'b1;
    end
  end

  // CTRL and sticky flag next state; set wins over a coincident clear
  always_comb begin
    ctrl_d   = ctrl_q;
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (ctrl_wr) begin
      ctrl_d = wb_dat_i[2:0];
    end
    if (status_wr) begin
      if (wb_dat_i[4]) tx_ovf_d = 1'b0;
      if (wb_dat_i[5]) rx_udf_d = 1'b0;
    end
    if (data_wr && tx_full) begin
      tx_ovf_d = 1'b1;
    end
    if (data_rd && rx_empty) begin
      rx_udf_d = 1'b1;
    end
  end

  // TX FIFO next state; flush overrides push and discards the contents
  always_comb begin
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = wb_dat_i;
      tx_wptr_d           = tx_wptr_q + PtrW'(1);
    end
    if (tx_pop) begin
      tx_rptr_d = tx_rptr_q + PtrW'(1);
    end
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + CntW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CntW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end
  end

  // RX FIFO next state; flush overrides the stream push
  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = rx_data;
      rx_wptr_d           = rx_wptr_q + PtrW'(1);
    end
    if (rx_pop) begin
      rx_rptr_d = rx_rptr_q + PtrW'(1);
    end
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CntW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CntW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    if (flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      dat_q     <= 8'h00;
      ctrl_q    <= 3'b000;
      tx_ovf_q  <= 1'b0;
      rx_udf_q  <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      ack_q     <= ack_d;
      done_q    <= done_d;
      dat_q     <= dat_d;
      ctrl_q    <= ctrl_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_udf_q  <= rx_udf_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // FIFO storage; contents are meaningless while the count says empty, so no reset
  always_ff @(posedge wb_clk_i) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule
